// File: rtl/mem_pkg.sv
// Shared types and helpers for the mem_dp_clr storage block.
// Holds the clear-sequencer state encoding plus byte-count and byte-parity helpers.
package mem_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } clr_state_e;

    function automatic int nbytes(input int width);
        return width / 32'sd8;
    endfunction

    // Even parity: the stored bit makes the byte plus parity bit have an even count of ones.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/mem_clr_fsm.sv
// Clear sequencer: sweeps every word to zero after reset or on clr_req,
// holding init_busy high for the whole sweep.
module mem_clr_fsm
    import mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int ADDR  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_req,
    output logic            init_busy,
    output logic            clr_we,
    output logic [ADDR-1:0] clr_addr
);

    localparam logic [ADDR-1:0] LAST_PTR = ADDR'(DEPTH - 32'sd1);

    clr_state_e      state_r, state_s;
    logic [ADDR-1:0] ptr_r, ptr_s;
    logic            busy_r;

    // State, sweep pointer and busy flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= CLEAR;
            ptr_r   <= '0;
            busy_r  <= 1'b1;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            busy_r  <= (state_s == CLEAR);
        end
    end

    // Next-state logic; a request arriving mid-sweep is ignored.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        case (state_r)
            CLEAR: begin
                if (ptr_r == LAST_PTR) begin
                    state_s = IDLE;
                    ptr_s   = '0;
                end else begin
                    state_s = CLEAR;
                    ptr_s   = ptr_r + ADDR'(1'b1);
                end
            end
            IDLE: begin
                if (clr_req) begin
                    state_s = CLEAR;
                    ptr_s   = '0;
                end else begin
                    state_s = IDLE;
                    ptr_s   = '0;
                end
            end
            default: begin
                state_s = CLEAR;
                ptr_s   = '0;
            end
        endcase
    end

    assign init_busy = busy_r;
    assign clr_we    = (state_r == CLEAR);
    assign clr_addr  = ptr_r;

endmodule

// File: rtl/mem_dp_clr.sv
// Simple-dual-port memory with byte enables, write-first forwarding and a clear sweep.
// Optional per-byte even parity when MEM_PARITY_EN is defined.
module mem_dp_clr
    import mem_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    parameter int ADDR  = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_req,
    output logic                     init_busy,
    input  logic                     wr_en,
    input  logic [ADDR-1:0]          wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [nbytes(WIDTH)-1:0] wr_be,
    input  logic                     rd_en,
    input  logic [ADDR-1:0]          rd_addr,
`ifdef MEM_PARITY_EN
    input  logic                     par_inj,
`endif
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     addr_err,
    output logic                     rd_perr
);

    localparam int              NB      = nbytes(WIDTH);
    localparam logic [ADDR:0]   DEPTH_C = (ADDR + 1)'(DEPTH);

    logic             busy_s, clr_we_s;
    logic [ADDR-1:0]  clr_addr_s;
    logic             wr_ok_s, rd_ok_s, wr_oor_s, rd_oor_s, hit_s;
    logic [WIDTH-1:0] fwd_data_s;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rd_data_r;
    logic             rd_valid_r, addr_err_r;

    mem_clr_fsm #(.DEPTH(DEPTH), .ADDR(ADDR)) u_clr_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_req   (clr_req),
        .init_busy (busy_s),
        .clr_we    (clr_we_s),
        .clr_addr  (clr_addr_s)
    );

    assign wr_ok_s  = !busy_s && wr_en && ({1'b0, wr_addr} <  DEPTH_C);
    assign wr_oor_s = !busy_s && wr_en && ({1'b0, wr_addr} >= DEPTH_C);
    assign rd_ok_s  = !busy_s && rd_en && ({1'b0, rd_addr} <  DEPTH_C);
    assign rd_oor_s = !busy_s && rd_en && ({1'b0, rd_addr} >= DEPTH_C);
    assign hit_s    = wr_ok_s && (wr_addr == rd_addr);

    // Array write port; the sweep owns the array while busy. No reset on storage.
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem_r[clr_addr_s] <= '0;
        end else if (wr_ok_s) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_be[k]) begin
                    mem_r[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    // Write-first merge: enabled bytes of a same-address write replace stored bytes.
    always_comb begin
        fwd_data_s = '0;
        for (int k = 0; k < NB; k++) begin
            fwd_data_s[8*k +: 8] = (hit_s && wr_be[k]) ? wr_data[8*k +: 8]
                                                       : mem_r[rd_addr][8*k +: 8];
        end
    end

    // Read output registers; out-of-range reads return zero with valid set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
            addr_err_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_ok_s || rd_oor_s;
            addr_err_r <= wr_oor_s || rd_oor_s;
            if (rd_ok_s) begin
                rd_data_r <= fwd_data_s;
            end else if (rd_oor_s) begin
                rd_data_r <= '0;
            end
        end
    end

`ifdef MEM_PARITY_EN
    logic [NB-1:0] par_r [DEPTH];
    logic [NB-1:0] fwd_par_s, chk_par_s;
    logic          rd_perr_r;

    // Parity storage tracks the data array; par_inj flips stored parity for enabled bytes.
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            par_r[clr_addr_s] <= '0;
        end else if (wr_ok_s) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_be[k]) begin
                    par_r[wr_addr][k] <= byte_parity(wr_data[8*k +: 8]) ^ par_inj;
                end
            end
        end
    end

    // Forwarded stored parity versus parity recomputed from the forwarded data.
    always_comb begin
        fwd_par_s = '0;
        chk_par_s = '0;
        for (int k = 0; k < NB; k++) begin
            fwd_par_s[k] = (hit_s && wr_be[k]) ? (byte_parity(wr_data[8*k +: 8]) ^ par_inj)
                                               : par_r[rd_addr][k];
            chk_par_s[k] = byte_parity(fwd_data_s[8*k +: 8]);
        end
    end

    // Parity error flag, aligned with rd_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_perr_r <= 1'b0;
        end else begin
            rd_perr_r <= rd_ok_s && (|(fwd_par_s ^ chk_par_s));
        end
    end

    assign rd_perr = rd_perr_r;
`else
    assign rd_perr = 1'b0;
`endif

    assign init_busy = busy_s;
    assign rd_data   = rd_data_r;
    assign rd_valid  = rd_valid_r;
    assign addr_err  = addr_err_r;

endmodule
